note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
Parametrised record/playback engine for fretboard note words; the next generation of the guitar recorder datapath. Runs an internal tempo tick, OR-accumulates note_in over each beat, stores one word per beat in an internal DEPTH-entry memory, and replays the stored sequence at the same tempo, optionally looping. Sits between the coordinate converter (producer of note_in) and the audio module (consumer of note_out), commanded by the top-level mode FSM.

Parameters:
NOTE_W, 30, width of a note word (strings x fret positions)
DEPTH, 64, number of storable beats (power of two, >=2)
ADDR_W, 6, log2(DEPTH)
CNT_W, 27, width of tempo counter / beat_period

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cmd_record  input  1  one-cycle pulse: start new recording
cmd_play  input  1  one-cycle pulse: start playback
cmd_stop  input  1  one-cycle pulse: abort record/play
loop_en  input  1  1 = playback wraps to address 0 after last note
beat_period  input  CNT_W  clocks per beat; sampled at every counter reload
note_in  input  NOTE_W  live note word
note_out  output  NOTE_W  current playback note
note_valid  output  1  one-cycle strobe: note_out just updated
beat_tick  output  1  one-cycle strobe at each beat in RECORD/PLAY
state_o  output  2  0 IDLE, 1 RECORD, 2 PLAY, 3 DONE
address  output  ADDR_W  current memory pointer
length  output  ADDR_W+1  number of stored beats (0..DEPTH)
full  output  1  length == DEPTH

Behaviour:
- Reset (synchronous, clk edge with reset=1): state IDLE, address 0, length 0, note_out 0, note_valid 0, beat_tick 0, accumulator 0, counter 0. Memory contents not cleared. Reset overrides any command in the same cycle.
- Command priority when simultaneous: cmd_stop > cmd_record > cmd_play.
- Tempo counter: on entry to RECORD or PLAY loads max(beat_period,1)-1; decrements each cycle; at 0 asserts beat_tick for that cycle and reloads (beat_period re-sampled). beat_period=0 or 1 -> tick every cycle. Counter idle and beat_tick 0 in IDLE/DONE.
- IDLE/DONE: cmd_record -> RECORD (address 0, length 0, accumulator 0). cmd_play with length>0 -> PLAY (address 0); with length=0 ignored. cmd_stop -> IDLE. note_out held.
- RECORD: each cycle accumulator |= note_in. On beat_tick cycle: mem[address] <= accumulator | note_in; accumulator <= 0; length <= address+1; if address==DEPTH-1 -> DONE (full=1, address stays DEPTH-1) else address+1. cmd_stop -> DONE; partial beat discarded, length unchanged. cmd_record restarts recording; cmd_play ignored.
- PLAY: on beat_tick cycle memory read of mem[address]; next cycle note_out = word, note_valid=1 for exactly one cycle (read latency 1). Address advances on the tick cycle. After the tick reading address length-1: loop_en=1 -> address 0, stay PLAY; loop_en=0 -> DONE after the final note_valid. First note appears beat_period+1 cycles after cmd_play. cmd_stop -> IDLE, note_out <= 0, pending note_valid suppressed. cmd_record -> RECORD (overwrites). loop_en sampled at wrap decision.
- note_valid and beat_tick never asserted outside RECORD/PLAY except the trailing note_valid of the final note.
- full reflects length combinationally; length never exceeds DEPTH.

Test Plan:
- DEPTH=8, beat_period=4: reset, cmd_record, note_in=0x1 for 2 cycles then 0x40 for 2 cycles, 3 beats, cmd_stop -> length=3, mem[0]=0x41, state DONE, beat_tick every 4 cycles.
- After above, cmd_play, loop_en=0 -> note_valid at cycles 5, 9, 13 after cmd_play with note_out 0x41 then stored words; state DONE; note_out holds last word.
- loop_en=1, length=3, play 7 beats -> note_out sequence mem[0],mem[1],mem[2],mem[0],mem[1],mem[2],mem[0]; cmd_stop -> IDLE, note_out=0, no further note_valid.
- Record 10 beats into DEPTH=8 -> DONE after 8th tick, full=1, length=8, address=7, beats 9-10 not written.
- cmd_play with length=0 -> stays IDLE; cmd_stop+cmd_record same cycle -> IDLE; beat_period=0 -> beat_tick every cycle in RECORD.
- Reset asserted mid-PLAY with cmd_play same cycle -> IDLE, note_out=0, length=0, note_valid=0 next cycle.

Source files
------------

// File: rtl/note_sequencer.sv
// Beat-quantised record/playback engine for fretboard note words.
// A tempo counter paces both modes; playback reads one stored word per beat.
module note_sequencer #(
  parameter int NOTE_W = 30,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_record,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              loop_en,
  input  logic [CNT_W-1:0]  beat_period,
  input  logic [NOTE_W-1:0] note_in,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              beat_tick,
  output logic [1:0]        state_o,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W:0]   length,
  output logic              full
);

  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  reload;
  logic [NOTE_W-1:0] acc;
  logic [NOTE_W-1:0] mem [DEPTH];
  logic              running, tick;
  logic              start_rec, start_play;
  logic              rec_beat, play_beat, last_beat;

  // A period of 0 behaves like 1: tick on every cycle.
  assign reload    = (beat_period == '0) ? '0 : beat_period - 1'b1;
  assign running   = (state == S_RECORD) || (state == S_PLAY);
  assign tick      = running && (cnt == '0);
  assign last_beat = (({1'b0, address} + 1'b1) == length);
  assign rec_beat  = (state == S_RECORD) && tick && !cmd_stop && !cmd_record;
  assign play_beat = (state == S_PLAY) && tick && !cmd_stop && !cmd_record;
  assign full      = (length == LEN_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_rec  = 1'b0;
    start_play = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (cmd_stop) state_nxt = S_IDLE;
        else if (cmd_record) begin
          state_nxt = S_RECORD;
          start_rec = 1'b1;
        end else if (cmd_play && (length != '0)) begin
          state_nxt  = S_PLAY;
          start_play = 1'b1;
        end
      end
      S_RECORD: begin
        if (cmd_stop) state_nxt = S_DONE;
        else if (cmd_record) start_rec = 1'b1;
        else if (rec_beat && (address == ADDR_LAST)) state_nxt = S_DONE;
      end
      S_PLAY: begin
        if (cmd_stop) state_nxt = S_IDLE;
        else if (cmd_record) begin
          state_nxt = S_RECORD;
          start_rec = 1'b1;
        end else if (play_beat && last_beat && !loop_en) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    beat_tick = tick;
    state_o   = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      address <= '0;
      length  <= '0;
    end else begin
      if (start_rec || start_play)
        cnt <= reload;
      else if ((state_nxt == S_RECORD) || (state_nxt == S_PLAY))
        cnt <= tick ? reload : cnt - 1'b1;
      else
        cnt <= '0;

      // Partial beats are dropped on stop/restart; the tick word is flushed to memory.
      if ((state == S_RECORD) && !cmd_stop && !cmd_record && !tick)
        acc <= acc | note_in;
      else
        acc <= '0;

      if (start_rec) begin
        address <= '0;
        length  <= '0;
      end else if (start_play) begin
        address <= '0;
      end else if (rec_beat) begin
        length <= {1'b0, address} + 1'b1;
        if (address != ADDR_LAST) address <= address + 1'b1;
      end else if (play_beat) begin
        if (!last_beat)   address <= address + 1'b1;
        else if (loop_en) address <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rec_beat) mem[address] <= acc | note_in;
  end

  // Read stage: word fetched on the tick edge, presented with note_valid one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      note_out   <= '0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= play_beat;
      if ((state == S_PLAY) && cmd_stop) note_out <= '0;
      else if (play_beat)                note_out <= mem[address];
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer (DEPTH=8): vector table, corner sequences and a
// randomized run against a beat-window reference model.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset, cmd_record, cmd_play, cmd_stop, loop_en;
  logic [26:0] beat_period;
  logic [29:0] note_in, note_out;
  logic        note_valid, beat_tick, full;
  logic [1:0]  state_o;
  logic [2:0]  address;
  logic [3:0]  length;

  note_sequencer #(.NOTE_W(30), .DEPTH(8), .ADDR_W(3), .CNT_W(27)) dut (
    .clk(clk), .reset(reset), .cmd_record(cmd_record), .cmd_play(cmd_play),
    .cmd_stop(cmd_stop), .loop_en(loop_en), .beat_period(beat_period),
    .note_in(note_in), .note_out(note_out), .note_valid(note_valid),
    .beat_tick(beat_tick), .state_o(state_o), .address(address),
    .length(length), .full(full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic rec, play, stop;
    logic [29:0] note;
    logic [1:0] st;
    logic tk, vl;
    logic [29:0] out;
    logic [3:0] len;
    logic [2:0] adr;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cmd_record = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0; note_in = '0;
  endtask

  task automatic addv(input int rec, input int play, input int stop, input int note,
                      input int st, input int tk, input int vl, input int out,
                      input int len, input int adr);
    vec_t v;
    v.rec = 1'(rec); v.play = 1'(play); v.stop = 1'(stop); v.note = 30'(note);
    v.st = 2'(st); v.tk = 1'(tk); v.vl = 1'(vl); v.out = 30'(out);
    v.len = 4'(len); v.adr = 3'(adr);
    vt.push_back(v);
  endtask

  // Reference model: beats are windows of P cycles after mode entry.
  int          m_st, m_t, m_len, m_addr, m_P;
  logic [29:0] m_mem [8];
  logic [29:0] m_out;
  logic        m_vld, m_tick;
  logic [29:0] win_q[$];

  task automatic model_reset(input int bp);
    m_st = 0; m_t = 0; m_len = 0; m_addr = 0; m_out = '0; m_vld = 1'b0;
    m_P = (bp == 0) ? 1 : bp;
    win_q.delete();
  endtask

  task automatic model_restart_rec();
    m_st = 1; m_t = 0; m_addr = 0; m_len = 0;
    win_q.delete();
  endtask

  task automatic model_step();
    logic [29:0] w;
    logic nv;
    nv = 1'b0;
    case (m_st)
      0, 3: begin
        if (cmd_stop) m_st = 0;
        else if (cmd_record) model_restart_rec();
        else if (cmd_play && m_len > 0) begin m_st = 2; m_t = 0; m_addr = 0; end
      end
      1: begin
        if (cmd_stop) begin m_st = 3; win_q.delete(); end
        else if (cmd_record) model_restart_rec();
        else begin
          win_q.push_back(note_in);
          if (m_tick) begin
            w = '0;
            foreach (win_q[k]) w |= win_q[k];
            m_mem[m_addr] = w;
            win_q.delete();
            m_len = m_addr + 1;
            if (m_addr == 7) m_st = 3; else m_addr++;
          end
          m_t++;
        end
      end
      default: begin
        if (cmd_stop) begin m_st = 0; m_out = '0; end
        else if (cmd_record) model_restart_rec();
        else begin
          if (m_tick) begin
            m_out = m_mem[m_addr];
            nv = 1'b1;
            if (m_addr == m_len - 1) begin
              if (loop_en) m_addr = 0; else m_st = 3;
            end else m_addr++;
          end
          m_t++;
        end
      end
    endcase
    m_vld = nv;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks;
    logic [29:0] got [8];
    logic [29:0] ew [10];
    logic [29:0] acc;
    logic [29:0] exp_loop [7];
    int bps [4];
    logic [63:0] act, exp;

    reset = 1'b1; loop_en = 1'b0; beat_period = 27'd4;
    idle_in();
    cyc(); cyc();
    reset = 1'b0;
    chk("reset state", state_o, 0);
    chk("reset address", address, 0);
    chk("reset length", length, 0);
    chk("reset note_out", note_out, 0);
    chk("reset note_valid", note_valid, 0);
    chk("reset beat_tick", beat_tick, 0);
    chk("reset full", full, 0);

    // Record 3 beats of 4 cycles, stop, then play once.
    addv(1,0,0,0,      0,0,0,0,0,0);
    for (int k = 0; k < 2; k++) addv(0,0,0,'h1, 1,0,0,0,0,0);
    addv(0,0,0,'h40,   1,0,0,0,0,0);
    addv(0,0,0,'h40,   1,1,0,0,0,0);
    for (int k = 0; k < 3; k++) addv(0,0,0,'h2, 1,0,0,0,1,1);
    addv(0,0,0,'h2,    1,1,0,0,1,1);
    for (int k = 0; k < 3; k++) addv(0,0,0,'h100, 1,0,0,0,2,2);
    addv(0,0,0,'h100,  1,1,0,0,2,2);
    addv(0,0,1,0,      1,0,0,0,3,3);
    addv(0,1,0,0,      3,0,0,0,3,3);
    for (int k = 0; k < 3; k++) addv(0,0,0,0, 2,0,0,0,3,0);
    addv(0,0,0,0,      2,1,0,0,3,0);
    addv(0,0,0,0,      2,0,1,'h41,3,1);
    for (int k = 0; k < 2; k++) addv(0,0,0,0, 2,0,0,'h41,3,1);
    addv(0,0,0,0,      2,1,0,'h41,3,1);
    addv(0,0,0,0,      2,0,1,'h2,3,2);
    for (int k = 0; k < 2; k++) addv(0,0,0,0, 2,0,0,'h2,3,2);
    addv(0,0,0,0,      2,1,0,'h2,3,2);
    addv(0,0,0,0,      3,0,1,'h100,3,2);
    addv(0,0,0,0,      3,0,0,'h100,3,2);

    foreach (vt[i]) begin
      cmd_record = vt[i].rec; cmd_play = vt[i].play; cmd_stop = vt[i].stop;
      note_in = vt[i].note;
      chk($sformatf("vec%0d state", i), state_o, vt[i].st);
      chk($sformatf("vec%0d tick", i), beat_tick, vt[i].tk);
      chk($sformatf("vec%0d valid", i), note_valid, vt[i].vl);
      chk($sformatf("vec%0d note_out", i), note_out, vt[i].out);
      chk($sformatf("vec%0d length", i), length, vt[i].len);
      chk($sformatf("vec%0d address", i), address, vt[i].adr);
      cyc();
    end
    idle_in();

    // Looped playback of the 3 stored words, then stop.
    exp_loop = '{30'h41, 30'h2, 30'h100, 30'h41, 30'h2, 30'h100, 30'h41};
    foreach (got[k]) got[k] = '0;
    loop_en = 1'b1; cmd_play = 1'b1; cyc(); cmd_play = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 7; c++) begin
      if (note_valid) begin got[n] = note_out; n++; end
      if (n == 7) cmd_stop = 1'b1;
      cyc();
    end
    cmd_stop = 1'b0;
    chk("loop note count", n, 7);
    for (int k = 0; k < 7; k++) chk($sformatf("loop word%0d", k), got[k], exp_loop[k]);
    chk("loop stop state", state_o, 0);
    chk("loop stop note_out", note_out, 0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (note_valid) n++;
      cyc();
    end
    chk("valid after stop", n, 0);
    loop_en = 1'b0;

    // Overfill: 10 beats into 8 entries, then play back everything.
    beat_period = 27'd2;
    cmd_record = 1'b1; cyc(); cmd_record = 1'b0;
    acc = '0; n = 0; ticks = 0;
    for (int c = 1; c <= 20; c++) begin
      note_in = 30'(1) << $urandom_range(0, 29);
      if (beat_tick) ticks++;
      if (c == 17) chk("done right after tick8", state_o, 3);
      acc |= note_in;
      if (c % 2 == 0) begin ew[n] = acc; acc = '0; n++; end
      cyc();
    end
    note_in = '0;
    chk("overfill tick count", ticks, 8);
    chk("overfill state", state_o, 3);
    chk("overfill full", full, 1);
    chk("overfill length", length, 8);
    chk("overfill address", address, 7);
    foreach (got[k]) got[k] = '0;
    cmd_play = 1'b1; cyc(); cmd_play = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (note_valid) begin got[n] = note_out; n++; end
      if (n == 8) break;
      cyc();
    end
    chk("full play count", n, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("full play word%0d", k), got[k], ew[k]);
    chk("final note state", state_o, 3);
    cyc();
    chk("after final valid", note_valid, 0);
    chk("note_out holds last", note_out, ew[7]);

    // Empty play, stop+record collision, zero period.
    reset = 1'b1; cyc(); reset = 1'b0;
    cmd_play = 1'b1; cyc(); cmd_play = 1'b0;
    chk("play empty stays idle", state_o, 0);
    cmd_stop = 1'b1; cmd_record = 1'b1; cyc(); idle_in();
    chk("stop beats record", state_o, 0);
    beat_period = 27'd0; note_in = 30'h5;
    cmd_record = 1'b1; cyc(); cmd_record = 1'b0;
    ticks = 0;
    for (int c = 0; c < 5; c++) begin
      if (beat_tick) ticks++;
      cyc();
    end
    chk("bp0 tick every cycle", ticks, 5);
    chk("bp0 length", length, 5);
    note_in = '0;
    cmd_stop = 1'b1; cyc(); cmd_stop = 1'b0;
    cmd_play = 1'b1; cyc(); cmd_play = 1'b0;
    for (int c = 0; c < 20 && !note_valid; c++) cyc();
    chk("bp0 play word", note_out, 30'h5);
    reset = 1'b1; cmd_play = 1'b1; cyc(); reset = 1'b0; cmd_play = 1'b0;
    chk("reset mid-play state", state_o, 0);
    chk("reset mid-play note_out", note_out, 0);
    chk("reset mid-play length", length, 0);
    chk("reset mid-play valid", note_valid, 0);
    cyc();
    chk("reset mid-play valid+1", note_valid, 0);

    // Randomized run against the reference model.
    bps = '{0, 1, 3, 5};
    foreach (bps[b]) begin
      beat_period = 27'(bps[b]);
      reset = 1'b1; idle_in(); cyc(); reset = 1'b0;
      model_reset(bps[b]);
      for (int c = 0; c < 500; c++) begin
        cmd_record = ($urandom_range(0, 39) == 0);
        cmd_play   = ($urandom_range(0, 14) == 0);
        cmd_stop   = ($urandom_range(0, 59) == 0);
        loop_en    = 1'($urandom_range(0, 1));
        note_in    = 30'($urandom);
        m_tick = ((m_st == 1) || (m_st == 2)) && (m_t % m_P == m_P - 1);
        act = {33'd0, state_o, beat_tick, note_valid, note_out, length, address, full};
        exp = {33'd0, 2'(m_st), m_tick, m_vld, m_out, 4'(m_len), 3'(m_addr), (m_len == 8)};
        chk($sformatf("rand bp%0d cyc%0d", bps[b], c), act, exp);
        model_step();
        cyc();
      end
    end
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
